// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 pipeline: default widths, memory-access FSM
// encoding and helpers that decode the sampled control flags of an instruction.
package swt16_pkg;

  localparam int SWT16_DMEM_ADDR_WIDTH = 12;
  localparam int SWT16_DMEM_WORD_WIDTH = 16;
  localparam int SWT16_IALU_WORD_WIDTH = 16;
  localparam int SWT16_REG_IDX_WIDTH   = 4;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_WAIT_RD = 1'b1;

  // Field order matches the {flush, load, store, write} concatenation used when sampling.
  typedef struct packed {
    logic flush;
    logic load;
    logic store;
    logic write;
  } ctrl_t;

  // A store wins over a load when both flags are set; a flushed slot does nothing.
  function automatic logic is_load(input ctrl_t c);
    return c.load & ~c.store & ~c.flush;
  endfunction

  function automatic logic is_store(input ctrl_t c);
    return c.store & ~c.flush;
  endfunction

  function automatic logic is_write(input ctrl_t c);
    return c.write & ~c.flush;
  endfunction

endpackage

// File: rtl/memacc.sv
// Memory-access pipeline stage: issues data-memory loads/stores, stalls upstream
// while a load is outstanding and produces the registered register-file write-back.
module memacc
  import swt16_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = SWT16_DMEM_ADDR_WIDTH,
  parameter int DMEM_WORD_WIDTH = SWT16_DMEM_WORD_WIDTH,
  parameter int IALU_WORD_WIDTH = SWT16_IALU_WORD_WIDTH,
  parameter int REG_IDX_WIDTH   = SWT16_REG_IDX_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_flush,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_dmem_rd_en,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word,
  input  logic                       in_dmem_rd_valid,
  output logic                       out_dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_stall,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  logic [0:0]                 r_state;
  logic [0:0]                 w_state_next;

  ctrl_t                      r_ctrl;
  logic [DMEM_ADDR_WIDTH-1:0] r_rd_addr;
  logic [DMEM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] r_wr_word;
  logic [IALU_WORD_WIDTH-1:0] r_res;
  logic [REG_IDX_WIDTH-1:0]   r_res_reg_idx;

  logic                       r_wb_act;
  logic [IALU_WORD_WIDTH-1:0] r_wb_res;
  logic [REG_IDX_WIDTH-1:0]   r_wb_idx;

  logic                       w_load_issue;
  logic                       w_load_busy;
  logic                       w_rd_done;
  logic                       w_stall;
  logic                       w_store;
  logic [IALU_WORD_WIDTH-1:0] w_rd_word;

  // The read request lasts only the issue cycle; WAIT_RD just waits for valid.
  assign w_load_issue = (r_state == ST_IDLE) && is_load(r_ctrl);
  assign w_load_busy  = w_load_issue || (r_state == ST_WAIT_RD);
  assign w_rd_done    = w_load_busy && in_dmem_rd_valid;
  assign w_stall      = w_load_busy && !in_dmem_rd_valid;
  assign w_store      = is_store(r_ctrl);
  assign w_rd_word    = IALU_WORD_WIDTH'(in_dmem_rd_word);

  assign out_dmem_rd_en   = w_load_issue;
  assign out_dmem_rd_addr = w_load_issue ? r_rd_addr : '0;
  assign out_dmem_wr_en   = w_store;
  assign out_dmem_wr_addr = w_store ? r_wr_addr : '0;
  assign out_dmem_wr_word = w_store ? r_wr_word : '0;
  assign out_stall        = w_stall;

  assign out_act_write_res_to_reg = r_wb_act;
  assign out_res                  = r_wb_res;
  assign out_res_reg_idx          = r_wb_idx;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_load_issue && !in_dmem_rd_valid) w_state_next = ST_WAIT_RD;
      ST_WAIT_RD: if (in_dmem_rd_valid) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stage registers freeze while stalled so the pending load keeps its flag and index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ctrl        <= '0;
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_wr_word     <= '0;
      r_res         <= '0;
      r_res_reg_idx <= '0;
    end else if (!w_stall) begin
      r_ctrl        <= {in_flush, in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg};
      r_rd_addr     <= in_dmem_rd_addr;
      r_wr_addr     <= in_dmem_wr_addr;
      r_wr_word     <= in_dmem_wr_word;
      r_res         <= in_res;
      r_res_reg_idx <= in_res_reg_idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wb_act <= 1'b0;
      r_wb_res <= '0;
      r_wb_idx <= '0;
    end else if (w_rd_done) begin
      r_wb_act <= r_ctrl.write;
      r_wb_res <= w_rd_word;
      r_wb_idx <= r_res_reg_idx;
    end else if (!w_load_busy && is_write(r_ctrl)) begin
      r_wb_act <= 1'b1;
      r_wb_res <= r_res;
      r_wb_idx <= r_res_reg_idx;
    end else begin
      r_wb_act <= 1'b0;
      r_wb_res <= '0;
      r_wb_idx <= '0;
    end
  end

endmodule

// File: doc/memacc.md
MEMACC -- requirements
Module: memacc

Interface
REQ-001 SHALL have parameter DMEM_ADDR_WIDTH, default 12, data-memory address width.
REQ-002 SHALL have parameter DMEM_WORD_WIDTH, default 16, data-memory word width.
REQ-003 SHALL have parameter IALU_WORD_WIDTH, default 16, result word width.
REQ-004 SHALL have parameter REG_IDX_WIDTH, default 4, register index width.
REQ-005 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port in_flush, input, 1, kill the instruction presented this cycle.
REQ-008 SHALL have port in_act_load_dmem, input, 1, instruction is a load.
REQ-009 SHALL have port in_act_store_dmem, input, 1, instruction is a store.
REQ-010 SHALL have port in_act_write_res_to_reg, input, 1, instruction writes a register.
REQ-011 SHALL have port in_dmem_rd_addr, input, DMEM_ADDR_WIDTH, load address.
REQ-012 SHALL have port in_dmem_wr_addr, input, DMEM_ADDR_WIDTH, store address.
REQ-013 SHALL have port in_dmem_wr_word, input, DMEM_WORD_WIDTH, store data.
REQ-014 SHALL have port in_res, input, IALU_WORD_WIDTH, ALU result.
REQ-015 SHALL have port in_res_reg_idx, input, REG_IDX_WIDTH, destination register.
REQ-016 SHALL have port out_dmem_rd_en, output, 1, memory read request.
REQ-017 SHALL have port out_dmem_rd_addr, output, DMEM_ADDR_WIDTH, read address.
REQ-018 SHALL have port in_dmem_rd_word, input, DMEM_WORD_WIDTH, read data.
REQ-019 SHALL have port in_dmem_rd_valid, input, 1, read data valid.
REQ-020 SHALL have port out_dmem_wr_en, output, 1, memory write strobe.
REQ-021 SHALL have port out_dmem_wr_addr, output, DMEM_ADDR_WIDTH, write address.
REQ-022 SHALL have port out_dmem_wr_word, output, DMEM_WORD_WIDTH, write data.
REQ-023 SHALL have port out_stall, output, 1, upstream must hold its outputs.
REQ-024 SHALL have ports out_act_write_res_to_reg (1), out_res (IALU_WORD_WIDTH) and out_res_reg_idx (REG_IDX_WIDTH), all outputs, forming the registered write-back to the register file.

Function
REQ-025 SHALL sample all in_* pipeline inputs into stage registers on each edge with out_stall=0, and hold them when out_stall=1.
REQ-026 SHALL implement FSM IDLE/WAIT_RD: IDLE->WAIT_RD on a sampled, unflushed load without in_dmem_rd_valid; WAIT_RD->IDLE on in_dmem_rd_valid.
REQ-027 SHALL assert out_dmem_rd_en combinationally for exactly one cycle (IDLE, sampled unflushed load), with out_dmem_rd_addr = sampled address; otherwise rd_en=0 and addr=0.
REQ-028 SHALL drive out_stall = (load issued or WAIT_RD) AND NOT in_dmem_rd_valid, so a zero-wait memory (valid in issue cycle) causes no stall.
REQ-029 SHALL on in_dmem_rd_valid for a pending load register in_dmem_rd_word into out_res, set out_act_write_res_to_reg to the load's sampled write flag, and set out_res_reg_idx.
REQ-030 SHALL for non-load instructions register in_res, write flag and index into write-back outputs one edge after sampling (total latency 2 edges from input).
REQ-031 SHALL insert a bubble (out_act_write_res_to_reg=0, out_res=0, out_res_reg_idx=0) on every write-back edge where no result completes.
REQ-032 SHALL assert out_dmem_wr_en for one cycle for a sampled unflushed store, with sampled address/word; otherwise all write outputs 0; stores never stall.
REQ-033 SHALL treat load and store both set as a store; the load is ignored.
REQ-034 SHALL treat a sampled in_flush=1 as a no-op: no memory strobe, no write-back, no stall.
REQ-035 SHALL ignore in_dmem_rd_valid in IDLE with no load issued; in_flush never cancels a load in WAIT_RD.

Reset
REQ-036 SHALL on reset force state IDLE and all stage and write-back registers to 0, so every output is 0 during and after reset.
REQ-037 SHALL abandon a load pending at reset; a later stray in_dmem_rd_valid produces no write-back.

Structure
REQ-038 SHALL take width parameters and the FSM state encoding from shared package swt16_pkg; single module, no sub-module.

Verification
REQ-039 ALU op res=0x1234, idx=3, write=1 -> out_res=0x1234, idx=3, write=1 two edges later, no stall.
REQ-040 Load addr=0x010, valid 3 cycles after rd_en, word=0xBEEF -> rd_en one cycle, stall 3 cycles, then write-back 0xBEEF.
REQ-041 Load with valid in issue cycle, word=0x0001 -> out_stall stays 0, write-back next edge.
REQ-042 Store addr=0x020, word=0x5A5A with in_flush=1 -> wr_en stays 0; repeat with flush=0 -> one wr_en pulse.
REQ-043 Reset asserted mid WAIT_RD, then valid pulse -> all outputs 0, no write-back.
